// File: rtl/step_ramp_gen_if.sv
// step_ramp_gen_if: move-command handshake plus step strobe/status bundle for step_ramp_gen
interface step_ramp_gen_if #(parameter int STEPS_W = 16);
  logic cmd_valid, cmd_ready, cmd_dir, stop, step_pulse, step_dir, busy, done;
  logic [STEPS_W-1:0] cmd_steps;
  modport master(output cmd_valid, cmd_steps, cmd_dir, stop, input cmd_ready, step_pulse, step_dir, busy, done);
  modport slave(input cmd_valid, cmd_steps, cmd_dir, stop, output cmd_ready, step_pulse, step_dir, busy, done);
endinterface

// File: rtl/step_ramp_gen.sv
// step_ramp_gen: trapezoidal step-pulse generator feeding the stepper phase sequencer
module step_ramp_gen #(
  parameter int PER_W = 24,
  parameter int STEPS_W = 16,
  parameter int MAX_PERIOD = 2000000,
  parameter int MIN_PERIOD = 400000,
  parameter int ACCEL_STEP = 100000
) (
  input logic clk,
  input logic rst,
  step_ramp_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;
  localparam logic [PER_W-1:0] maxPer = PER_W'(MAX_PERIOD);
  localparam logic [PER_W-1:0] minPer = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] accStep = PER_W'(ACCEL_STEP);
  state_t state, stateN;
  logic [PER_W-1:0] curPeriod, periodN, timer, timerN, decSat, incSat;
  logic [PER_W:0] incSum;
  logic [STEPS_W-1:0] remaining, remN, rampCnt, rampN, rem;
  logic [STEPS_W:0] stopCap;
  logic accept, fire, fin, pulseN, doneN, busyN, readyN, dirN;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign rem = remaining - STEPS_W'(1);
  assign decSat = (curPeriod - minPer) < accStep ? minPer : curPeriod - accStep;
  assign incSum = {1'b0, curPeriod} + {1'b0, accStep};
  assign incSat = incSum > {1'b0, maxPer} ? maxPer : incSum[PER_W-1:0];
  assign stopCap = {1'b0, rampN} + (STEPS_W+1)'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= stateN;
  // The last pulse leaves remaining at 0; the following cycle retires the move, so done trails it by one
  always_comb begin
    stateN = state;
    periodN = curPeriod;
    timerN = timer;
    remN = remaining;
    rampN = rampCnt;
    fire = 1'b0;
    fin = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        stateN = ACCEL;
        periodN = maxPer;
        timerN = maxPer;
        remN = bus.cmd_steps;
        rampN = '0;
      end
    end else if (remaining == '0) begin
      stateN = IDLE;
      fin = 1'b1;
    end else begin
      timerN = timer - PER_W'(1);
      if (timer == PER_W'(1)) begin
        fire = 1'b1;
        remN = rem;
        if (rem != '0 && rem <= rampCnt) begin
          stateN = DECEL;
          periodN = incSat;
          rampN = rampCnt - STEPS_W'(1);
        end else if (rem != '0 && state == ACCEL && curPeriod > minPer) begin
          periodN = decSat;
          rampN = rampCnt + STEPS_W'(1);
          stateN = decSat == minPer ? CRUISE : ACCEL;
        end
        timerN = periodN;
      end
      if (bus.stop && state != DECEL && {1'b0, remN} > stopCap) remN = stopCap[STEPS_W-1:0];
    end
  end
  always_comb begin
    pulseN = fire;
    doneN = fin;
    busyN = stateN != IDLE;
    readyN = stateN == IDLE && !fin;
    dirN = accept ? bus.cmd_dir : bus.step_dir;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      curPeriod <= '0;
      timer <= '0;
      remaining <= '0;
      rampCnt <= '0;
      bus.step_pulse <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.step_dir <= 1'b0;
    end else begin
      curPeriod <= periodN;
      timer <= timerN;
      remaining <= remN;
      rampCnt <= rampN;
      bus.step_pulse <= pulseN;
      bus.done <= doneN;
      bus.busy <= busyN;
      bus.cmd_ready <= readyN;
      bus.step_dir <= dirN;
    end
endmodule

// File: tb/tb_step_ramp_gen.sv
// tb_step_ramp_gen: per-cycle comparison of step_ramp_gen against a pulse-schedule model
module tb_step_ramp_gen;
  localparam int MAXP = 100, MINP = 40, ACC = 20, N = 16384;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  step_ramp_gen_if #(.STEPS_W(16)) bus();
  step_ramp_gen #(.PER_W(24), .STEPS_W(16), .MAX_PERIOD(MAXP), .MIN_PERIOD(MINP), .ACCEL_STEP(ACC))
    dut(.clk(clk), .rst(rst), .bus(bus));
  int cyc = 0, checks = 0, errors = 0;
  bit ePulse[N], eBusy[N], eDone[N], eReady[N], eDir[N];
  int prof[$];
  int exp10[10] = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
  int exp3[3] = '{100, 80, 100};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk)
    if (cyc < N) begin
      check("step_pulse", int'(bus.step_pulse), int'(ePulse[cyc]));
      check("busy", int'(bus.busy), int'(eBusy[cyc]));
      check("done", int'(bus.done), int'(eDone[cyc]));
      check("cmd_ready", int'(bus.cmd_ready), int'(eReady[cyc]));
      check("step_dir", int'(bus.step_dir), int'(eDir[cyc]));
    end
  // Interval list of a move, one entry per pulse; stop is seen between pulse stopAfter and the next
  task automatic buildProfile(int steps, int stopAfter);
    int per = MAXP, k = 0, rem = steps, n = 0;
    bit decel = 1'b0;
    prof.delete();
    while (rem > 0) begin
      prof.push_back(per);
      rem--;
      n++;
      if (rem == 0) break;
      if (rem <= k) begin
        decel = 1'b1;
        per = per + ACC > MAXP ? MAXP : per + ACC;
        k--;
      end else if (!decel && per > MINP) begin
        per = per - ACC < MINP ? MINP : per - ACC;
        k++;
      end
      if (n == stopAfter && !decel && rem > k + 1) rem = k + 1;
    end
  endtask
  task automatic plan(int a, bit dir, output int last);
    int t = a;
    foreach (prof[i]) begin
      t += prof[i];
      ePulse[t] = 1'b1;
    end
    last = t;
    for (int n = a; n < N; n++) eDir[n] = dir;
    for (int n = a; n <= last; n++) eBusy[n] = 1'b1;
    for (int n = a; n <= last + 1; n++) eReady[n] = 1'b0;
    eDone[last+1] = 1'b1;
  endtask
  task automatic clearFrom(int s);
    for (int n = s; n < N; n++) begin
      ePulse[n] = 1'b0;
      eBusy[n] = 1'b0;
      eDone[n] = 1'b0;
      eReady[n] = 1'b1;
      eDir[n] = 1'b0;
    end
  endtask
  task automatic startMove(int steps, bit dir, int stopAfter, bit hold, output int a, output int last);
    int p;
    for (int w = 0; w < 4000 && !eReady[cyc]; w++) @(negedge clk);
    check("ready_wait", int'(eReady[cyc]), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = 16'(steps);
    bus.cmd_dir = dir;
    a = cyc + 1;
    buildProfile(steps, stopAfter);
    plan(a, dir, last);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    if (stopAfter > 0) begin
      p = a;
      for (int i = 0; i < stopAfter; i++) p += prof[i];
      repeat (p + 1 - cyc) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a, last, a2, last2, sum;
    bus.cmd_valid = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_dir = 1'b0;
    bus.stop = 1'b0;
    for (int n = 0; n < N; n++) eReady[n] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", int'(bus.cmd_ready), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_dir", int'(bus.step_dir), 0);
    startMove(10, 1'b1, 0, 1'b0, a, last);
    check("p10_len", prof.size(), 10);
    sum = 0;
    foreach (prof[i]) sum += prof[i];
    check("p10_total", sum, 640);
    for (int i = 0; i < 10 && i < prof.size(); i++) check("p10_iv", prof[i], exp10[i]);
    repeat (last + 3 - cyc) @(negedge clk);
    startMove(3, 1'b0, 0, 1'b0, a, last);
    check("p3_len", prof.size(), 3);
    for (int i = 0; i < 3 && i < prof.size(); i++) check("p3_iv", prof[i], exp3[i]);
    repeat (last + 3 - cyc) @(negedge clk);
    startMove(0, 1'b1, 0, 1'b0, a, last);
    check("p0_len", prof.size(), 0);
    repeat (last + 3 - cyc) @(negedge clk);
    startMove(50, 1'b0, 6, 1'b0, a, last);
    check("stop_len", prof.size(), 10);
    for (int i = 0; i < 10 && i < prof.size(); i++) check("stop_iv", prof[i], exp10[i]);
    repeat (last + 3 - cyc) @(negedge clk);
    startMove(2, 1'b1, 0, 1'b1, a, last);
    bus.cmd_steps = 16'd3;
    bus.cmd_dir = 1'b0;
    startMove(3, 1'b0, 0, 1'b0, a2, last2);
    check("held_accept_gap", a2 - last, 3);
    repeat (last2 + 3 - cyc) @(negedge clk);
    startMove(50, 1'b1, 0, 1'b0, a, last);
    repeat (a + 320 - 1 - cyc) @(negedge clk);
    @(posedge clk);
    #1;
    check("pulse_before_rst", int'(bus.step_pulse), 1);
    #1;
    rst = 1'b0;
    clearFrom(cyc);
    #1;
    check("rst_pulse", int'(bus.step_pulse), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ready", int'(bus.cmd_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
